// File: rtl/tlights_pkg.sv
// Shared definitions for the red/amber/green light bus: phase, fault and
// checker-state encodings plus pattern decode helpers.
package tlights_pkg;

    typedef enum logic [1:0] {
        PH_R  = 2'b00,
        PH_RA = 2'b01,
        PH_G  = 2'b10,
        PH_A  = 2'b11
    } phase_e;

    typedef enum logic [1:0] {
        FLT_NONE    = 2'b00,
        FLT_ILLEGAL = 2'b01,
        FLT_ORDER   = 2'b10,
        FLT_TIMEOUT = 2'b11
    } fault_e;

    typedef enum logic [1:0] {
        ACQUIRE = 2'b00,
        TRACK   = 2'b01,
        FAULT   = 2'b10
    } state_e;

    // Bit order is {R, A, G}.
    localparam logic [2:0] RAG_R  = 3'b100;
    localparam logic [2:0] RAG_RA = 3'b110;
    localparam logic [2:0] RAG_G  = 3'b001;
    localparam logic [2:0] RAG_A  = 3'b010;

    function automatic logic [2:0] pattern_of(input phase_e ph);
        case (ph)
            PH_R:    return RAG_R;
            PH_RA:   return RAG_RA;
            PH_G:    return RAG_G;
            default: return RAG_A;
        endcase
    endfunction

    function automatic phase_e next_phase(input phase_e ph);
        case (ph)
            PH_R:    return PH_RA;
            PH_RA:   return PH_G;
            PH_G:    return PH_A;
            default: return PH_R;
        endcase
    endfunction

    function automatic logic is_legal(input logic [2:0] rag);
        return (rag == RAG_R) || (rag == RAG_RA) || (rag == RAG_G) || (rag == RAG_A);
    endfunction

endpackage

// File: rtl/tlights_monitor.sv
// Watchdog that locks onto the R -> RA -> G -> A -> R light sequence,
// enforces per-phase dwell limits and latches the first fault seen.
module tlights_monitor
    import tlights_pkg::*;
#(
    parameter int MAX_DWELL = 16,
    parameter int CYC_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       rag,
    input  logic             clr,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CYC_W-1:0] cycles,
    output logic             cycle_done
);

    localparam int DW_W = $clog2(MAX_DWELL + 1);

    state_e           r_state;
    phase_e           r_phase;
    fault_e           r_code;
    logic [DW_W-1:0]  r_dwell;
    logic [CYC_W-1:0] r_cycles;
    logic             r_cycle_done;

    logic [2:0]       w_cur_pat;
    logic [2:0]       w_nxt_pat;
    logic [DW_W:0]    w_dwell_inc;
    logic             w_timeout;

    // One extra bit so MAX_DWELL+1 is representable when MAX_DWELL is 2^n-1.
    assign w_cur_pat   = pattern_of(r_phase);
    assign w_nxt_pat   = pattern_of(next_phase(r_phase));
    assign w_dwell_inc = {1'b0, r_dwell} + (DW_W + 1)'(1);
    assign w_timeout   = w_dwell_inc > (DW_W + 1)'(MAX_DWELL);

    // NOTE: sequential state uses non-blocking (<=) so every register sees
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ACQUIRE;
            r_phase      <= PH_R;
            r_code       <= FLT_NONE;
            r_dwell      <= '0;
            r_cycles     <= '0;
            r_cycle_done <= 1'b0;
        end else begin
            r_cycle_done <= 1'b0;
            if (clr) begin
                r_state  <= ACQUIRE;
                r_phase  <= PH_R;
                r_code   <= FLT_NONE;
                r_dwell  <= '0;
                r_cycles <= '0;
            end else begin
                case (r_state)
                    ACQUIRE: begin
                        if (rag == RAG_R) begin
                            r_state <= TRACK;
                            r_phase <= PH_R;
                            r_dwell <= DW_W'(1);
                        end
                    end
                    TRACK: begin
                        if (rag == w_cur_pat) begin
                            if (w_timeout) begin
                                r_state <= FAULT;
                                r_code  <= FLT_TIMEOUT;
                            end else begin
                                r_dwell <= w_dwell_inc[DW_W-1:0];
                            end
                        end else if (rag == w_nxt_pat) begin
                            r_phase <= next_phase(r_phase);
                            r_dwell <= DW_W'(1);
                            if (r_phase == PH_A) begin
                                r_cycle_done <= 1'b1;
                                if (!(&r_cycles)) r_cycles <= r_cycles + CYC_W'(1);
                            end
                        end else if (is_legal(rag)) begin
                            r_state <= FAULT;
                            r_code  <= FLT_ORDER;
                        end else begin
                            r_state <= FAULT;
                            r_code  <= FLT_ILLEGAL;
                        end
                    end
                    default: ; // FAULT is sticky until clr or reset
                endcase
            end
        end
    end

    assign phase      = r_phase;
    assign locked     = (r_state == TRACK);
    assign fault      = (r_state == FAULT);
    assign fault_code = r_code;
    assign cycles     = r_cycles;
    assign cycle_done = r_cycle_done;

endmodule

// File: tb/tb_tlights_monitor.sv
// Scoreboard bench for tlights_monitor: a MAX_DWELL=16 instance and a
// MAX_DWELL=4 / CYC_W=2 instance share the same stimulus.
module tb_tlights_monitor;
    import tlights_pkg::*;

    typedef struct packed {
        logic [1:0] phase;
        logic       locked;
        logic       fault;
        logic [1:0] code;
        logic       cdone;
        logic [7:0] cycles;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rag = 3'b000;
    logic       clr = 1'b0;

    logic [1:0] phase_a, phase_b;
    logic       locked_a, locked_b, fault_a, fault_b, cdone_a, cdone_b;
    logic [1:0] code_a, code_b;
    logic [7:0] cycles_a;
    logic [1:0] cycles_b;

    int vectors = 0;
    int miscompares = 0;
    obs_t sb[$];

    always #5 clk = ~clk;

    tlights_monitor #(.MAX_DWELL(16), .CYC_W(8)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .rag(rag), .clr(clr),
        .phase(phase_a), .locked(locked_a), .fault(fault_a),
        .fault_code(code_a), .cycles(cycles_a), .cycle_done(cdone_a)
    );

    tlights_monitor #(.MAX_DWELL(4), .CYC_W(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .rag(rag), .clr(clr),
        .phase(phase_b), .locked(locked_b), .fault(fault_b),
        .fault_code(code_b), .cycles(cycles_b), .cycle_done(cdone_b)
    );

    function automatic obs_t mk(input logic [1:0] ph, input logic lk, input logic ft,
                                input logic [1:0] cd, input logic dn, input logic [7:0] cy);
        obs_t o;
        o.phase = ph; o.locked = lk; o.fault = ft; o.code = cd; o.cdone = dn; o.cycles = cy;
        return o;
    endfunction

    function automatic obs_t observe(input bit sel4);
        if (sel4) return mk(phase_b, locked_b, fault_b, code_b, cdone_b, {6'b0, cycles_b});
        return mk(phase_a, locked_a, fault_a, code_a, cdone_a, cycles_a);
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic drive(input logic [2:0] r, input logic c);
        @(negedge clk);
        rag = r;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, want;
        @(negedge clk);
        rst_n = 1'b0; rag = 3'b000; clr = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sb.push_back(mk(2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0));
            got  = observe(s[0]);
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset[dut%0d] got %h want %h", s, got, want);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lock_and_count();
        logic [2:0] pat[6];
        obs_t e[6];
        obs_t got, want;
        pat = '{RAG_R, RAG_RA, RAG_G, RAG_A, RAG_R, RAG_R};
        e[0] = mk(2'd0, 1, 0, 2'd0, 0, 8'd0);
        e[1] = mk(2'd1, 1, 0, 2'd0, 0, 8'd0);
        e[2] = mk(2'd2, 1, 0, 2'd0, 0, 8'd0);
        e[3] = mk(2'd3, 1, 0, 2'd0, 0, 8'd0);
        e[4] = mk(2'd0, 1, 0, 2'd0, 1, 8'd1);
        e[5] = mk(2'd0, 1, 0, 2'd0, 0, 8'd1);
        for (int i = 0; i < 6; i++) begin
            sb.push_back(e[i]);
            drive(pat[i], 1'b0);
            got  = observe(1'b0);
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL lock_count[%0d] got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_acquire_filter();
        logic [2:0] pat[4];
        obs_t e[4];
        obs_t got, want;
        pat = '{RAG_G, RAG_A, 3'b111, RAG_R};
        for (int i = 0; i < 3; i++) e[i] = mk(2'd0, 0, 0, 2'd0, 0, 8'd0);
        e[3] = mk(2'd0, 1, 0, 2'd0, 0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            sb.push_back(e[i]);
            drive(pat[i], 1'b0);
            got  = observe(1'b0);
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL acquire[%0d] got %h want %h", i, got, want);
            end
        end
    endtask

    // Continues from the locked-in-R state left by test_acquire_filter.
    task automatic test_order_fault();
        logic [2:0] pat[3];
        obs_t got, want;
        pat = '{RAG_G, 3'b111, RAG_R};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(2'd0, 0, 1, 2'd2, 0, 8'd0));
            drive(pat[i], 1'b0);
            got  = observe(1'b0);
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL order[%0d] got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_timeout();
        logic [2:0] pat[7];
        logic       c[7];
        obs_t e[7];
        obs_t got, want;
        pat = '{RAG_R, RAG_R, RAG_R, RAG_R, RAG_R, RAG_R, RAG_R};
        c   = '{0, 0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 4; i++) e[i] = mk(2'd0, 1, 0, 2'd0, 0, 8'd0);
        e[4] = mk(2'd0, 0, 1, 2'd3, 0, 8'd0);
        e[5] = mk(2'd0, 0, 0, 2'd0, 0, 8'd0);
        e[6] = mk(2'd0, 1, 0, 2'd0, 0, 8'd0);
        for (int i = 0; i < 7; i++) begin
            sb.push_back(e[i]);
            drive(pat[i], c[i]);
            got  = observe(1'b1);
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL timeout[%0d] got %h want %h", i, got, want);
            end
        end
        clr = 1'b0;
    endtask

    task automatic test_clr_priority();
        logic [2:0] pat[5];
        logic       c[5];
        obs_t e[5];
        obs_t got, want;
        pat = '{RAG_R, RAG_RA, RAG_G, 3'b101, RAG_R};
        c   = '{0, 0, 0, 1, 0};
        e[0] = mk(2'd0, 1, 0, 2'd0, 0, 8'd0);
        e[1] = mk(2'd1, 1, 0, 2'd0, 0, 8'd0);
        e[2] = mk(2'd2, 1, 0, 2'd0, 0, 8'd0);
        e[3] = mk(2'd0, 0, 0, 2'd0, 0, 8'd0);
        e[4] = mk(2'd0, 1, 0, 2'd0, 0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            sb.push_back(e[i]);
            drive(pat[i], c[i]);
            got  = observe(1'b0);
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL clr_prio[%0d] got %h want %h", i, got, want);
            end
        end
        clr = 1'b0;
    endtask

    // Two-bit counter on the small instance saturates at 3 after four cycles.
    task automatic test_saturation();
        logic [2:0] pat[4];
        logic [7:0] exp_cyc;
        obs_t got, want;
        pat = '{RAG_RA, RAG_G, RAG_A, RAG_R};
        exp_cyc = 8'd0;
        drive(RAG_R, 1'b0);
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (j == 3 && exp_cyc != 8'd3) exp_cyc = exp_cyc + 8'd1;
                sb.push_back(mk(2'((j + 1) % 4), 1, 0, 2'd0, (j == 3), exp_cyc));
                drive(pat[j], 1'b0);
                got  = observe(1'b1);
                want = sb.pop_front();
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL saturate[%0d.%0d] got %h want %h", k, j, got, want);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t got, want;
        drive(RAG_R, 1'b0);
        drive(RAG_RA, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sb.push_back(mk(2'd0, 0, 0, 2'd0, 0, 8'd0));
            got  = observe(s[0]);
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL async_rst[dut%0d] got %h want %h", s, got, want);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(mk(2'd0, 0, 0, 2'd0, 0, 8'd0));
        drive(RAG_G, 1'b0);
        got  = observe(1'b0);
        want = sb.pop_front();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL async_rel_acq got %h want %h", got, want);
        end
        sb.push_back(mk(2'd0, 1, 0, 2'd0, 0, 8'd0));
        drive(RAG_R, 1'b0);
        got  = observe(1'b0);
        want = sb.pop_front();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL async_rel_lock got %h want %h", got, want);
        end
    endtask

    initial begin
        test_reset();
        test_lock_and_count();
        test_reset();
        test_acquire_filter();
        test_order_fault();
        test_reset();
        test_timeout();
        test_reset();
        test_clr_priority();
        test_reset();
        test_saturation();
        test_reset();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
